// File: rtl/axi_sram_slave.sv
// AXI3 memory-side slave backed by a word-addressed array, with independent read and write FSMs.
// Define AXI_SLV_DELAY_EN to insert RESP_DELAY wait cycles before the first R beat and before B.
module axi_sram_slave #(
    parameter int ADDR_BITS  = 12,
    parameter int RESP_DELAY = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd3;
`ifdef AXI_SLV_DELAY_EN
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] B_WAIT = 2'd2;
    logic [7:0] r_dly;
    logic [7:0] w_dly;
`endif

    logic [31:0] mem [DEPTH];

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_idx;
    logic [3:0]           r_len;
    logic [3:0]           r_cnt;
    logic [1:0]           r_burst;
    logic                 r_ok;

    logic [1:0]           w_state;
    logic [ADDR_BITS-1:0] w_idx;
    logic [3:0]           w_len;
    logic [4:0]           w_cnt;
    logic [1:0]           w_burst;
    logic                 w_ok;
    logic                 b_err;

    logic ar_fire, r_fire, aw_fire, w_fire;

    assign ar_fire = arvalid & arready;
    assign r_fire  = rvalid & rready;
    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;

    assign r_ok = (r_burst == BURST_FIXED) || (r_burst == BURST_INCR);
    assign w_ok = (w_burst == BURST_FIXED) || (w_burst == BURST_INCR);

    function automatic logic [ADDR_BITS-1:0] next_idx(input logic [ADDR_BITS-1:0] idx,
                                                     input logic [1:0]           burst);
        return (burst == BURST_INCR) ? idx + ADDR_BITS'(1) : idx;
    endfunction

    // NOTE: rdata reads the array combinationally, so a stalled beat follows writes to its word
    // and a same-cycle write is only visible after the clock edge.
    assign rvalid = (r_state == R_DATA);
    assign rlast  = rvalid && (r_cnt == r_len);
    assign rresp  = (rvalid && !r_ok) ? RESP_SLVERR : RESP_OKAY;
    assign rdata  = (rvalid && r_ok) ? mem[r_idx] : '0;

    assign wready = (w_state == W_DATA);
    assign bvalid = (w_state == W_RESP);
    assign bresp  = (bvalid && b_err) ? RESP_SLVERR : RESP_OKAY;

    // NOTE: all FSM state is updated with non-blocking assignments so every branch sees
    // the values from the start of the cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rid     <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
`ifdef AXI_SLV_DELAY_EN
            r_dly   <= '0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_fire) begin
                        arready <= 1'b0;
                        rid     <= arid;
                        r_idx   <= araddr[ADDR_BITS+1:2];
                        r_len   <= arlen[3:0];
                        r_burst <= arburst;
                        r_cnt   <= '0;
`ifdef AXI_SLV_DELAY_EN
                        r_dly   <= '0;
                        r_state <= (RESP_DELAY == 0) ? R_DATA : R_WAIT;
`else
                        r_state <= R_DATA;
`endif
                    end
                end
`ifdef AXI_SLV_DELAY_EN
                R_WAIT: begin
                    if (r_dly == 8'(RESP_DELAY - 1)) r_state <= R_DATA;
                    else                             r_dly   <= r_dly + 8'd1;
                end
`endif
                R_DATA: begin
                    if (r_fire) begin
                        r_cnt <= r_cnt + 4'd1;
                        r_idx <= next_idx(r_idx, r_burst);
                        if (rlast) begin
                            r_state <= R_IDLE;
                            arready <= 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            bid     <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            b_err   <= 1'b0;
`ifdef AXI_SLV_DELAY_EN
            w_dly   <= '0;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (aw_fire) begin
                        awready <= 1'b0;
                        bid     <= awid;
                        w_idx   <= awaddr[ADDR_BITS+1:2];
                        w_len   <= awlen[3:0];
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 5'd1;
                        w_idx <= next_idx(w_idx, w_burst);
                        // Only wlast ends the burst; a beat count that disagrees with len is reported in B.
                        if (wlast) begin
                            b_err <= !w_ok || (w_cnt != {1'b0, w_len});
`ifdef AXI_SLV_DELAY_EN
                            w_dly   <= '0;
                            w_state <= (RESP_DELAY == 0) ? W_RESP : B_WAIT;
`else
                            w_state <= W_RESP;
`endif
                        end
                    end
                end
`ifdef AXI_SLV_DELAY_EN
                B_WAIT: begin
                    if (w_dly == 8'(RESP_DELAY - 1)) w_state <= W_RESP;
                    else                             w_dly   <= w_dly + 8'd1;
                end
`endif
                W_RESP: begin
                    if (bready) begin
                        w_state <= W_IDLE;
                        awready <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset; its contents must survive areset.
    always_ff @(posedge aclk) begin
        if (!areset && w_fire && w_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{araddr[31:ADDR_BITS+2], araddr[1:0], arlen[7:4], arsize, arlock,
                             arcache, arprot, awaddr[31:ADDR_BITS+2], awaddr[1:0], awlen[7:4],
                             awsize, awlock, awcache, awprot, wid, 32'(RESP_DELAY)};
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave that serves as the memory-side responder for the CPU top's AXI master port. It stands in for the SoC memory in simulation and in memory-only builds.
- Backed by an internal word-addressed register array. Read and write channels run as independent FSMs, with one outstanding transaction per direction.
- Supports INCR and FIXED bursts, up to 16 beats each.

Parameters:
ADDR_BITS, 12, log2 of memory depth in 32-bit words; the word index is addr[ADDR_BITS+1:2], and higher bits are ignored (aliasing).
RESP_DELAY, 2, extra idle cycles before the first R beat and before B. Used only when AXI_SLV_DELAY_EN is defined.

Ports:
aclk  input  1  clock
areset  input  1  synchronous, active-high reset
arid, awid  input  4  read / write transaction ID
araddr, awaddr  input  32  byte address
arlen, awlen  input  8  beats-1; only bits [3:0] are used
arsize, awsize  input  3  ignored; every beat is a full word
arburst, awburst  input  2  00 FIXED, 01 INCR, others unsupported
arlock/arcache/arprot, awlock/awcache/awprot  input  2/4/3  ignored
arvalid, awvalid  input  1  address valid
arready, awready  output  1  address accepted
rid  output  4  latched arid
rdata  output  32  read beat data
rresp, bresp  output  2  00 OKAY, 10 SLVERR
rlast  output  1  final read beat
rvalid  output  1  read beat valid
rready  input  1  master accepts beat
wid  input  4  ignored
wdata  input  32  write beat data
wstrb  input  4  byte enables
wlast  input  1  final write beat
wvalid  input  1  write beat valid
wready  output  1  write beat accepted
bid  output  4  latched awid
bvalid  output  1  write response valid
bready  input  1  master accepts response

Behaviour:
- Reset: every output is 0, including arready, awready, wready, rvalid, rlast, bvalid, rid, bid, rdata, rresp and bresp.
  - arready and awready rise 1 cycle after areset deasserts.
  - Reset mid-burst drops the burst with no response. Memory contents are retained and never cleared.
- Read FSM:
  - R_IDLE (arready=1): on arvalid&arready, latch id, word index, len[3:0] and burst; clear the beat counter; go to R_DATA.
  - R_DATA (arready=0): rvalid=1 from the cycle after the handshake.
    - rdata = mem[idx], read combinationally, so it reflects the array state in that cycle.
    - rlast=(cnt==len); rid=latched id.
    - Outputs are held stable while rvalid&!rready, except that rdata tracks writes to idx that complete during the stall.
  - On rvalid&rready: cnt+1. idx+1 for INCR (wraps modulo depth); idx unchanged for FIXED.
  - The beat with rlast goes to R_IDLE, and arready=1 the next cycle. Back-to-back reads therefore need at least 1 bubble.
  - Unsupported burst: all len+1 beats return rresp=10 and rdata=0.
- Write FSM:
  - W_IDLE (awready=1): on handshake, latch id, idx, len and burst; clear cnt; go to W_DATA.
  - W_DATA (wready=1): on each wvalid&wready, write the byte lanes enabled by wstrb into mem[idx], then cnt+1 and advance idx per burst as for reads.
    - Unsupported burst: accept the beats but perform no writes.
    - The wlast handshake goes to W_RESP. The FSM does not stop at len+1 beats; it only stops on wlast.
  - W_RESP: bvalid=1, bid=latched id.
    - bresp=10 if the burst was unsupported or the wlast beat count != len; otherwise 00.
    - Hold until bready, then go to W_IDLE.
  - W data presented before the AW handshake is not accepted (wready=0 in W_IDLE).
- Simultaneous read and write to the same word: the write takes effect at the clock edge. A read beat that completes in the same cycle returns the old data.

Optional Feature:
- AXI_SLV_DELAY_EN defined: a counter inserts RESP_DELAY cycles in R_WAIT before R_DATA, and in B_WAIT before W_RESP. The first rvalid comes RESP_DELAY+1 cycles after the AR handshake, and bvalid comes RESP_DELAY+1 cycles after the wlast handshake.
- Undefined: both latencies are 1 cycle and the wait states do not exist.

Test Plan:
- Write awaddr=0x100, awlen=0, wdata=0xDEADBEEF, wstrb=F, awid=3, then read the same address with arid=5 -> bresp=00, bid=3; rdata=0xDEADBEEF, rlast=1, rid=5, rresp=00.
- Write 0x11223344, then wstrb=0101 with wdata=0xAABBCCDD -> read returns 0x11BB33DD.
- INCR write at 0x200, awlen=3, data 1,2,3,4; read back with rready toggling 1,0,0,1 -> 4 beats in order, rlast only on beat 4, beats stable while stalled, rvalid 1 cycle after the AR handshake.
- FIXED read at 0x200, arlen=1 -> two beats, both returning 1. arburst=10 -> rresp=10, rdata=0 on every beat.
- awlen=3 with wlast on beat 2 -> bresp=10, and words 0 and 1 written. Reset asserted during R_DATA -> rvalid=0 the next cycle, arready=1 one cycle after release, memory retained.
- With AXI_SLV_DELAY_EN and RESP_DELAY=2 -> first rvalid 3 cycles after the AR handshake, bvalid 3 cycles after the wlast handshake.
